regfile_write_arbiter: RTL and testbench

- Shares the register file's single write port (WriteRegister/WriteData/RegWrite) among NREQ writeback requesters, e.g. ALU, load unit, multiplier and commit.
- Round-robin arbitration with a valid/ready handshake per requester.
- One registered output stage drives the register file write port.
- Writes to the hard-wired zero register are accepted, then dropped and counted.

---
 rtl/regfile_write_arbiter.sv | 102 ++++++++++
 tb/tb_regfile_write_arbiter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register file write port among NREQ writeback requesters.
// Optional REGARB_PRIO0_EN gives requester 0 (commit) absolute priority over the others.
module regfile_write_arbiter #(
    parameter int unsigned NREQ     = 4,
    parameter int unsigned AW       = 5,
    parameter int unsigned DW       = 64,
    parameter int unsigned ZERO_REG = 31
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    req_valid_i,
    output logic [NREQ-1:0]    req_ready_o,
    input  logic [NREQ*AW-1:0] req_addr_i,
    input  logic [NREQ*DW-1:0] req_data_i,
    input  logic               hold_i,
    output logic               RegWrite,
    output logic [AW-1:0]      WriteRegister,
    output logic [DW-1:0]      WriteData,
    output logic               busy_o,
    output logic [15:0]        drop_cnt_o
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CW = 16;
    localparam logic [AW-1:0] ZeroAddr = AW'(ZERO_REG);
    localparam logic [CW-1:0] CntMax   = '1;
`ifdef REGARB_PRIO0_EN
    localparam bit Prio0 = 1'b1;
`else
    localparam bit Prio0 = 1'b0;
`endif

    logic [PW-1:0]   rrPtr;
    logic [PW-1:0]   nextPtr;
    logic [NREQ-1:0] grant;
    logic            grantValid;
    logic [AW-1:0]   selAddr;
    logic [DW-1:0]   selData;
    int unsigned     idx;

    // Pick the first valid requester at or after the pointer; requester 0 may preempt.
    always_comb begin : arbitrate
        grant      = '0;
        grantValid = 1'b0;
        nextPtr    = rrPtr;
        idx        = 0;
        if (!reset && !hold_i) begin
            if (Prio0 && req_valid_i[0]) begin
                grant[0]   = 1'b1;
                grantValid = 1'b1;
            end
            for (int unsigned i = 0; i < NREQ; i++) begin
                idx = (32'(rrPtr) + i) % NREQ;
                if (!grantValid && req_valid_i[PW'(idx)] && !(Prio0 && idx == 0)) begin
                    grant[PW'(idx)] = 1'b1;
                    grantValid      = 1'b1;
                    nextPtr         = PW'((idx + 1) % NREQ);
                end
            end
        end
    end

    always_comb begin : writeMux
        selAddr = '0;
        selData = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (grant[k]) begin
                selAddr = req_addr_i[k*AW +: AW];
                selData = req_data_i[k*DW +: DW];
            end
        end
    end

    assign req_ready_o = grant;
    assign busy_o      = !reset && (|(req_valid_i & ~grant));

    // Single output stage; zero-register writes are swallowed here and counted.
    always_ff @(posedge clk) begin : writeStage
        if (reset) begin
            rrPtr         <= '0;
            RegWrite      <= 1'b0;
            WriteRegister <= '0;
            WriteData     <= '0;
            drop_cnt_o    <= '0;
        end else begin
            rrPtr    <= nextPtr;
            RegWrite <= 1'b0;
            if (grantValid) begin
                if (selAddr == ZeroAddr) begin
                    if (drop_cnt_o != CntMax) begin
                        drop_cnt_o <= drop_cnt_o + CW'(1);
                    end
                end else begin
                    RegWrite      <= 1'b1;
                    WriteRegister <= selAddr;
                    WriteData     <= selData;
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomized scoreboard bench for regfile_write_arbiter: a reference model predicts grants
// and the per-cycle write port state; a monitor compares the registered outputs.
module tb_regfile_write_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 5;
    localparam int DW   = 64;
    localparam int ZREG = 31;

    logic               clk = 1'b0;
    logic               reset;
    logic               hold;
    logic [NREQ-1:0]    reqValid;
    logic [NREQ-1:0]    reqReady;
    logic [NREQ*AW-1:0] reqAddr;
    logic [NREQ*DW-1:0] reqData;
    logic               regWrite;
    logic [AW-1:0]      writeRegister;
    logic [DW-1:0]      writeData;
    logic               busy;
    logic [15:0]        dropCnt;

    regfile_write_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .ZERO_REG(ZREG)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid_i  (reqValid),
        .req_ready_o  (reqReady),
        .req_addr_i   (reqAddr),
        .req_data_i   (reqData),
        .hold_i       (hold),
        .RegWrite     (regWrite),
        .WriteRegister(writeRegister),
        .WriteData    (writeData),
        .busy_o       (busy),
        .drop_cnt_o   (dropCnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            we;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int            drop;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    bit   started = 1'b0;

    // Requester-side state, owned by the stimulus process
    bit            vld[NREQ];
    logic [AW-1:0] ad[NREQ];
    logic [DW-1:0] dt[NREQ];
    bit            accepted[NREQ];
    int            pValid, pHold, pReset, pZero;

    // Reference model state
    int            mPtr;
    logic [AW-1:0] mA;
    logic [DW-1:0] mD;
    int            mDrop;

    always_comb begin
        reqValid = '0;
        reqAddr  = '0;
        reqData  = '0;
        for (int k = 0; k < NREQ; k++) begin
            reqValid[k]          = vld[k];
            reqAddr[k*AW +: AW]  = ad[k];
            reqData[k*DW +: DW]  = dt[k];
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic newReq(input int k);
        vld[k] = 1'b1;
        ad[k]  = ($urandom % 100 < pZero) ? AW'(ZREG) : AW'($urandom_range(0, ZREG - 1));
        dt[k]  = {$urandom, $urandom};
    endtask

    // Reference model: predicts this cycle's grant and the write port after the next edge.
    always @(negedge clk) begin
        int   g;
        int   c;
        bit   b;
        exp_t e;
        started = 1'b1;
        if (reset) begin
            chk("ready_in_reset", 64'(reqReady), 64'(0));
            chk("busy_in_reset", 64'(busy), 64'(0));
            mPtr = 0; mA = '0; mD = '0; mDrop = 0;
            e.we = 1'b0; e.a = '0; e.d = '0; e.drop = 0;
        end else begin
            g = -1;
            if (!hold) begin
`ifdef REGARB_PRIO0_EN
                if (vld[0]) g = 0;
                for (int i = 0; i < NREQ; i++) begin
                    c = (mPtr + i) % NREQ;
                    if (g < 0 && c != 0 && vld[c]) g = c;
                end
`else
                for (int i = 0; i < NREQ; i++) begin
                    c = (mPtr + i) % NREQ;
                    if (g < 0 && vld[c]) g = c;
                end
`endif
            end
            b = 1'b0;
            for (int k = 0; k < NREQ; k++) if (vld[k] && k != g) b = 1'b1;
            chk("ready", 64'(reqReady), (g >= 0) ? (64'(1) << g) : 64'(0));
            chk("busy", 64'(busy), 64'(b));
            e.we = 1'b0;
            if (g >= 0) begin
                accepted[g] = 1'b1;
`ifdef REGARB_PRIO0_EN
                if (g != 0) mPtr = (g + 1) % NREQ;
`else
                mPtr = (g + 1) % NREQ;
`endif
                if (ad[g] == AW'(ZREG)) begin
                    if (mDrop < 65535) mDrop++;
                end else begin
                    e.we = 1'b1; mA = ad[g]; mD = dt[g];
                end
            end
            e.a = mA; e.d = mD; e.drop = mDrop;
        end
        sbq.push_back(e);
    end

    // Monitor: one expected port state per cycle, compared just after each rising edge.
    always @(posedge clk) begin
        exp_t e;
        #3;
        if (started) begin
            if (sbq.size() == 0) begin
                checks++; errors++;
                $display("FAIL scoreboard_empty: got no entry expected one at %0t", $time);
            end else begin
                e = sbq.pop_front();
                chk("RegWrite", 64'(regWrite), 64'(e.we));
                chk("WriteRegister", 64'(writeRegister), 64'(e.a));
                chk("WriteData", writeData, e.d);
                chk("drop_cnt", 64'(dropCnt), 64'(e.drop));
            end
        end
    end

    initial begin
        int phases[5][5] = '{
            '{300,  40,  0, 0, 15},
            '{200, 100,  0, 0, 10},
            '{300,  60, 20, 0, 20},
            '{300,  50, 10, 2, 15},
            '{200,  25,  5, 1, 50}
        };
        reset = 1'b1;
        hold  = 1'b0;
        pZero = 15;
        for (int k = 0; k < NREQ; k++) begin
            accepted[k] = 1'b0;
            newReq(k);
        end
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        for (int p = 0; p < 5; p++) begin
            pValid = phases[p][1];
            pHold  = phases[p][2];
            pReset = phases[p][3];
            pZero  = phases[p][4];
            for (int n = 0; n < phases[p][0]; n++) begin
                @(posedge clk);
                #1;
                for (int k = 0; k < NREQ; k++) begin
                    if (vld[k] && accepted[k]) vld[k] = 1'b0;
                    accepted[k] = 1'b0;
                    if (!vld[k] && ($urandom % 100 < pValid)) newReq(k);
                end
                hold  = ($urandom % 100 < pHold);
                reset = ($urandom % 100 < pReset);
            end
        end
        @(posedge clk);
        #4;
        chk("scoreboard_drained", 64'(sbq.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
